// File: rtl/seq_entry_ctrl.sv
// Push-button symbol entry: synchronise and debounce two buttons, shift accepted
// symbols into a history register and flag matches of PATTERN.
module seq_entry_ctrl #(
    parameter logic [7:0] PATTERN     = 8'b0000_1011,
    parameter int         PAT_LEN     = 4,
    parameter int         DEB_CYCLES  = 4,
    parameter int         HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_one,
    input  logic       btn_zero,
    input  logic       arm,
    input  logic       clr_cnt,
    output logic       sym_valid,
    output logic       sym_bit,
    output logic       match,
    output logic       match_led,
    output logic [7:0] match_cnt,
    output logic [1:0] state,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [PAT_LEN-1:0] PAT       = PATTERN[PAT_LEN-1:0];
    localparam logic [3:0]         FILL_MAX  = 4'(PAT_LEN);
    localparam logic [7:0]         DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0]         HOLD_LOAD = 8'(HOLD_CYCLES);

    // Bit 1 carries the '1' button, bit 0 the '0' button throughout.
    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [7:0]         dcnt_q [2];
    logic [7:0]         dcnt_d [2];
    logic [1:0]         rise;
    state_t             state_q, state_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [3:0]         fill_q, fill_d;
    logic [7:0]         timer_q, timer_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               sym_valid_q, sym_valid_d, sym_bit_q, sym_bit_d;
    logic               match_q, match_d, led_q, led_d, err_q, err_d;

    always_comb begin
        sync1_d    = {btn_one, btn_zero};
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < 2; i++) begin
            dcnt_d[i] = 8'd0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
                else                       dcnt_d[i] = dcnt_q[i] + 8'd1;
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        timer_d     = timer_q;
        sym_valid_d = 1'b0;
        sym_bit_d   = sym_bit_q;
        match_d     = 1'b0;
        case (state_q)
            IDLE: if (arm) state_d = RUN;
            RUN, HOLD: begin
                if (state_q == HOLD) begin
                    if (timer_q <= 8'd1) state_d = RUN;
                    else                 timer_d = timer_q - 8'd1;
                end
                if (rise == 2'b11) begin
                    state_d = FAULT;
                end else begin
                    // Match looks at the symbol shifted in on the previous edge.
                    if (sym_valid_q && fill_q == FILL_MAX && hist_q == PAT) begin
                        match_d = 1'b1;
                        state_d = HOLD;
                        timer_d = HOLD_LOAD;
                    end
                    if (rise != 2'b00) begin
                        sym_valid_d = 1'b1;
                        sym_bit_d   = rise[1];
                        hist_d      = {hist_q[PAT_LEN-2:0], rise[1]};
                        if (fill_q != FILL_MAX) fill_d = fill_q + 4'd1;
                    end
                end
            end
            default: state_d = FAULT;
        endcase
        if (!arm) begin
            state_d     = IDLE;
            sym_valid_d = 1'b0;
            match_d     = 1'b0;
            timer_d     = 8'd0;
        end
        if (state_d == IDLE) begin
            hist_d = '0;
            fill_d = 4'd0;
        end
        if (clr_cnt)                      cnt_d = 8'd0;
        else if (match_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        else                              cnt_d = cnt_q;
        led_d = (state_d == HOLD);
        err_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            deb_q       <= 2'b00;
            deb_prev_q  <= 2'b00;
            dcnt_q[0]   <= 8'd0;
            dcnt_q[1]   <= 8'd0;
            state_q     <= IDLE;
            hist_q      <= '0;
            fill_q      <= 4'd0;
            timer_q     <= 8'd0;
            cnt_q       <= 8'd0;
            sym_valid_q <= 1'b0;
            sym_bit_q   <= 1'b0;
            match_q     <= 1'b0;
            led_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            dcnt_q[0]   <= dcnt_d[0];
            dcnt_q[1]   <= dcnt_d[1];
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            sym_valid_q <= sym_valid_d;
            sym_bit_q   <= sym_bit_d;
            match_q     <= match_d;
            led_q       <= led_d;
            err_q       <= err_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym_bit   = sym_bit_q;
    assign match     = match_q;
    assign match_led = led_q;
    assign match_cnt = cnt_q;
    assign state     = state_q;
    assign err       = err_q;

endmodule
